// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared types and constants for the architectural register file.
//
// Optional feature macro used by this slice: RF_COMMIT_BYPASS_EN
//   (forwards a same-cycle, tag-matching commit to the read ports).
//
// Contents:
//   DATA_W_DEF / ROB_IDX_W_DEF : default widths for the register file
//   NUM_REGS                   : architectural register count (x0..x31)
//   word_t, rob_id_t, reg_idx_t: data word, ROB tag, register index
//   REG_ZERO                   : index of the hardwired-zero register
//   reg_state_e                : per-register rename state (the busy bit)
//   is_arch_reg()              : true for writable registers (x1..x31)
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ROB_IDX_W_DEF = 4;
  localparam int NUM_REGS      = 32;

  typedef logic [DATA_W_DEF-1:0]    word_t;
  typedef logic [ROB_IDX_W_DEF-1:0] rob_id_t;
  typedef logic [4:0]               reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Each register's busy bit is a two-state machine:
  //   FREE    -> PENDING on issue
  //   PENDING -> FREE    on tag-matching commit or clear
  //   PENDING -> PENDING on re-issue (retag)
  // The state register is exposed by the top as o_dbg_busy.
  typedef enum logic {
    REG_FREE    = 1'b0,
    REG_PENDING = 1'b1
  } reg_state_e;

  function automatic logic is_arch_reg(input reg_idx_t idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// -----------------------------------------------------------------------------
// reg_file_if
// Dispatcher/ROB facing bus of the register file.
//
// Signal groups:
//   read   : rs1_addr/rs2_addr in; rsX_val, rsX_busy, rsX_tag out
//   issue  : issue_en, issue_rd, issue_rob_id
//   commit : commit_en, commit_rd, commit_val, commit_rob_id
//   flush  : clear
//
// Handshake: there is no backpressure. issue_en, commit_en and clear are
// single-cycle qualifiers; a qualified request is consumed on every rising
// clock edge where the top-level rdy input is high and is ignored (not
// queued) when rdy is low. Read outputs are combinational and always valid.
//
// Modports: master = dispatcher/ROB side, slave = register file.
// -----------------------------------------------------------------------------
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF
);

  reg_idx_t               rs1_addr;
  reg_idx_t               rs2_addr;
  logic [DATA_W-1:0]      rs1_val;
  logic [DATA_W-1:0]      rs2_val;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic [ROB_IDX_W-1:0]   rs1_tag;
  logic [ROB_IDX_W-1:0]   rs2_tag;

  logic                   issue_en;
  reg_idx_t               issue_rd;
  logic [ROB_IDX_W-1:0]   issue_rob_id;

  logic                   commit_en;
  reg_idx_t               commit_rd;
  logic [DATA_W-1:0]      commit_val;
  logic [ROB_IDX_W-1:0]   commit_rob_id;

  logic                   clear;

  modport master (
    output rs1_addr, rs2_addr,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    output issue_en, issue_rd, issue_rob_id,
    output commit_en, commit_rd, commit_val, commit_rob_id,
    output clear
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
    input  issue_en, issue_rd, issue_rob_id,
    input  commit_en, commit_rd, commit_val, commit_rob_id,
    input  clear
  );

endinterface

// File: rtl/reg_file_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file: looks up value, busy
// bit and producer tag for i_addr, forces x0 to zero, and (when
// RF_COMMIT_BYPASS_EN is defined) forwards a same-cycle commit whose ROB id
// matches the register's current producer tag.
//
// Ports:
//   i_addr                      register index to read
//   i_val_arr/i_busy_vec/i_tag_arr  registered state of all 32 registers
//   i_commit_* (bypass build)   commit bus for forwarding
//   o_val, o_busy, o_tag        lookup result
// -----------------------------------------------------------------------------
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
  input  reg_idx_t              i_addr,
  input  logic [DATA_W-1:0]     i_val_arr [NUM_REGS],
  input  logic [NUM_REGS-1:0]   i_busy_vec,
  input  logic [ROB_IDX_W-1:0]  i_tag_arr [NUM_REGS],
`ifdef RF_COMMIT_BYPASS_EN
  input  logic                  i_commit_en,
  input  reg_idx_t              i_commit_rd,
  input  logic [DATA_W-1:0]     i_commit_val,
  input  logic [ROB_IDX_W-1:0]  i_commit_rob_id,
`endif
  output logic [DATA_W-1:0]     o_val,
  output logic                  o_busy,
  output logic [ROB_IDX_W-1:0]  o_tag
);

`ifdef RF_COMMIT_BYPASS_EN
  logic w_bypass_hit;

  // Forward only when the retiring instruction is the register's current
  // producer; an older producer of a retagged register must not clear busy.
  assign w_bypass_hit = i_commit_en
                     && is_arch_reg(i_addr)
                     && (i_commit_rd == i_addr)
                     && (i_commit_rob_id == i_tag_arr[i_addr]);
`endif

  always_comb begin
    o_val  = '0;
    o_busy = 1'b0;
    o_tag  = '0;
    if (is_arch_reg(i_addr)) begin
      o_val  = i_val_arr[i_addr];
      o_busy = i_busy_vec[i_addr];
      o_tag  = i_tag_arr[i_addr];
`ifdef RF_COMMIT_BYPASS_EN
      if (w_bypass_hit) begin
        o_val  = i_commit_val;
        o_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file with per-register rename status for the
// out-of-order core. The dispatcher reads operands plus producer ROB tags and
// marks destinations pending on issue; the ROB retires values in program
// order and flushes all pending marks on a misprediction (clear).
//
// Optional feature: define RF_COMMIT_BYPASS_EN to forward a same-cycle,
// tag-matching commit straight to the read ports. Without it, reads reflect
// registered state only.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   rdy         global enable; low holds all state (reads stay valid)
//   bus         reg_file_if.slave: read ports, issue, commit, clear
//   o_dbg_busy  per-register busy (FREE/PENDING) state vector, bit 0 = x0
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  reg_file_if.slave            bus,
  output logic [NUM_REGS-1:0]  o_dbg_busy
);

  // x0 entries are reset and never written, so they read as constant zero.
  logic [DATA_W-1:0]     r_val [NUM_REGS];
  logic [ROB_IDX_W-1:0]  r_tag [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;

  logic [NUM_REGS-1:0]   w_commit_sel;
  logic [NUM_REGS-1:0]   w_issue_sel;
  logic [NUM_REGS-1:0]   w_tag_match;

  // One-hot decode of commit/issue targets; x0 never selected.
  always_comb begin
    w_commit_sel = '0;
    w_issue_sel  = '0;
    w_tag_match  = '0;
    if (bus.commit_en && is_arch_reg(bus.commit_rd)) begin
      w_commit_sel[bus.commit_rd] = 1'b1;
    end
    if (bus.issue_en && is_arch_reg(bus.issue_rd)) begin
      w_issue_sel[bus.issue_rd] = 1'b1;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      w_tag_match[i] = (r_tag[i] == bus.commit_rob_id);
    end
  end

  // Update priority per register:
  //   value  : any commit to the register writes it (even under clear,
  //            since the retiring instruction is older than the flush)
  //   busy   : clear > issue (set + retag) > tag-matching commit (release)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_commit_sel[i]) begin
          r_val[i] <= bus.commit_val;
        end
        if (bus.clear) begin
          r_busy[i] <= 1'b0;
        end else if (w_issue_sel[i]) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= bus.issue_rob_id;
        end else if (w_commit_sel[i] && w_tag_match[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_dbg_busy = r_busy;

  rf_read_port #(
    .DATA_W    (DATA_W),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_rs1_port (
    .i_addr          (bus.rs1_addr),
    .i_val_arr       (r_val),
    .i_busy_vec      (r_busy),
    .i_tag_arr       (r_tag),
`ifdef RF_COMMIT_BYPASS_EN
    .i_commit_en     (bus.commit_en),
    .i_commit_rd     (bus.commit_rd),
    .i_commit_val    (bus.commit_val),
    .i_commit_rob_id (bus.commit_rob_id),
`endif
    .o_val           (bus.rs1_val),
    .o_busy          (bus.rs1_busy),
    .o_tag           (bus.rs1_tag)
  );

  rf_read_port #(
    .DATA_W    (DATA_W),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_rs2_port (
    .i_addr          (bus.rs2_addr),
    .i_val_arr       (r_val),
    .i_busy_vec      (r_busy),
    .i_tag_arr       (r_tag),
`ifdef RF_COMMIT_BYPASS_EN
    .i_commit_en     (bus.commit_en),
    .i_commit_rd     (bus.commit_rd),
    .i_commit_val    (bus.commit_val),
    .i_commit_rob_id (bus.commit_rob_id),
`endif
    .o_val           (bus.rs2_val),
    .o_busy          (bus.rs2_busy),
    .o_tag           (bus.rs2_tag)
  );

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed self-checking bench for reg_file. Inputs change on the falling
// edge; outputs are sampled on the following falling edge (state) or 1 ns
// after an input change (combinational read / asynchronous reset).
// -----------------------------------------------------------------------------
module tb_reg_file;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] dbg_busy;

  int n_cmp;
  int n_bad;

  reg_file_if #(.DATA_W(DW), .ROB_IDX_W(TW)) bus ();

  reg_file #(.DATA_W(DW), .ROB_IDX_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .bus        (bus),
    .o_dbg_busy (dbg_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    bus.issue_en      = 1'b0;
    bus.issue_rd      = '0;
    bus.issue_rob_id  = '0;
    bus.commit_en     = 1'b0;
    bus.commit_rd     = '0;
    bus.commit_val    = '0;
    bus.commit_rob_id = '0;
    bus.clear         = 1'b0;
  endtask

  task automatic drv_issue(input logic [4:0] rd, input logic [TW-1:0] id);
    bus.issue_en     = 1'b1;
    bus.issue_rd     = rd;
    bus.issue_rob_id = id;
  endtask

  task automatic drv_commit(input logic [4:0] rd, input logic [DW-1:0] v, input logic [TW-1:0] id);
    bus.commit_en     = 1'b1;
    bus.commit_rd     = rd;
    bus.commit_val    = v;
    bus.commit_rob_id = id;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd31;
    #2;
    n_cmp++; if (bus.rs1_val !== 32'h0) begin n_bad++; $display("FAIL reset_rs1_val got=%h exp=%h", bus.rs1_val, 32'h0); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL reset_rs1_busy got=%b exp=0", bus.rs1_busy); end
    n_cmp++; if (bus.rs2_tag !== 4'h0) begin n_bad++; $display("FAIL reset_rs2_tag got=%h exp=0", bus.rs2_tag); end
    n_cmp++; if (dbg_busy !== 32'h0) begin n_bad++; $display("FAIL reset_dbg_busy got=%h exp=0", dbg_busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_issue_commit();
    @(negedge clk);
    drv_issue(5'd5, 4'd3);
    next_cycle();
    bus.rs1_addr = 5'd5;
    #1;
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_bad++; $display("FAIL ic_busy got=%b exp=1", bus.rs1_busy); end
    n_cmp++; if (bus.rs1_tag !== 4'd3) begin n_bad++; $display("FAIL ic_tag got=%h exp=3", bus.rs1_tag); end
    n_cmp++; if (dbg_busy !== 32'h20) begin n_bad++; $display("FAIL ic_dbg got=%h exp=%h", dbg_busy, 32'h20); end
    drv_commit(5'd5, 32'hDEADBEEF, 4'd3);
    next_cycle();
    #1;
    n_cmp++; if (bus.rs1_val !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ic_val got=%h exp=deadbeef", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL ic_release got=%b exp=0", bus.rs1_busy); end
  endtask

  task automatic test_retag();
    @(negedge clk);
    drv_issue(5'd5, 4'd3);
    next_cycle();
    drv_issue(5'd5, 4'd7);
    next_cycle();
    drv_commit(5'd5, 32'h11, 4'd3);
    next_cycle();
    bus.rs2_addr = 5'd5;
    #1;
    n_cmp++; if (bus.rs2_val !== 32'h11) begin n_bad++; $display("FAIL retag_val got=%h exp=11", bus.rs2_val); end
    n_cmp++; if (bus.rs2_busy !== 1'b1) begin n_bad++; $display("FAIL retag_busy got=%b exp=1", bus.rs2_busy); end
    n_cmp++; if (bus.rs2_tag !== 4'd7) begin n_bad++; $display("FAIL retag_tag got=%h exp=7", bus.rs2_tag); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drv_commit(5'd6, 32'h22, 4'd2);
    drv_issue(5'd6, 4'd9);
    next_cycle();
    bus.rs1_addr = 5'd6;
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h22) begin n_bad++; $display("FAIL same_val got=%h exp=22", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_bad++; $display("FAIL same_busy got=%b exp=1", bus.rs1_busy); end
    n_cmp++; if (bus.rs1_tag !== 4'd9) begin n_bad++; $display("FAIL same_tag got=%h exp=9", bus.rs1_tag); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    drv_issue(5'd10, 4'd1);
    next_cycle();
    drv_issue(5'd11, 4'd2);
    next_cycle();
    drv_issue(5'd12, 4'd5);
    next_cycle();
    #1;
    // x5, x6 still pending from earlier tests, plus x10..x12
    n_cmp++; if (dbg_busy !== 32'h00001C60) begin n_bad++; $display("FAIL clr_pre got=%h exp=00001c60", dbg_busy); end
    bus.clear = 1'b1;
    drv_issue(5'd8, 4'd4);
    drv_commit(5'd10, 32'hAB, 4'd1);
    next_cycle();
    bus.rs1_addr = 5'd8;
    bus.rs2_addr = 5'd10;
    #1;
    n_cmp++; if (dbg_busy !== 32'h0) begin n_bad++; $display("FAIL clr_all got=%h exp=0", dbg_busy); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL clr_x8_busy got=%b exp=0", bus.rs1_busy); end
    n_cmp++; if (bus.rs2_val !== 32'hAB) begin n_bad++; $display("FAIL clr_commit_val got=%h exp=ab", bus.rs2_val); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drv_commit(5'd0, 32'h55, 4'd0);
    drv_issue(5'd0, 4'd1);
    next_cycle();
    bus.rs1_addr = 5'd0;
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h0) begin n_bad++; $display("FAIL x0_val got=%h exp=0", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL x0_busy got=%b exp=0", bus.rs1_busy); end
    n_cmp++; if (bus.rs1_tag !== 4'd0) begin n_bad++; $display("FAIL x0_tag got=%h exp=0", bus.rs1_tag); end
    n_cmp++; if (dbg_busy !== 32'h0) begin n_bad++; $display("FAIL x0_dbg got=%h exp=0", dbg_busy); end
  endtask

  task automatic test_rdy_hold();
    @(negedge clk);
    rdy = 1'b0;
    drv_issue(5'd7, 4'd3);
    drv_commit(5'd10, 32'h99, 4'd1);
    next_cycle();
    rdy = 1'b1;
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd10;
    #1;
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy got=%b exp=0", bus.rs1_busy); end
    n_cmp++; if (bus.rs2_val !== 32'hAB) begin n_bad++; $display("FAIL hold_val got=%h exp=ab", bus.rs2_val); end
  endtask

  // x5 holds 0x11, free, tag 7 on entry
  task automatic test_commit_visibility();
    @(negedge clk);
    drv_issue(5'd5, 4'd3);
    next_cycle();
    bus.rs1_addr = 5'd5;
    drv_commit(5'd5, 32'h66, 4'd2);  // wrong producer: never forwarded
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h11) begin n_bad++; $display("FAIL byp_nomatch_val got=%h exp=11", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_bad++; $display("FAIL byp_nomatch_busy got=%b exp=1", bus.rs1_busy); end
    next_cycle();
    drv_commit(5'd5, 32'h77, 4'd3);
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    n_cmp++; if (bus.rs1_val !== 32'h77) begin n_bad++; $display("FAIL byp_val got=%h exp=77", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL byp_busy got=%b exp=0", bus.rs1_busy); end
`else
    n_cmp++; if (bus.rs1_val !== 32'h66) begin n_bad++; $display("FAIL nobyp_val got=%h exp=66", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_bad++; $display("FAIL nobyp_busy got=%b exp=1", bus.rs1_busy); end
`endif
    next_cycle();
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h77) begin n_bad++; $display("FAIL vis_val got=%h exp=77", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL vis_busy got=%b exp=0", bus.rs1_busy); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    drv_issue(5'd9, 4'd6);
    next_cycle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd9;
    #2;
    rst = 1'b0;   // asynchronous, mid-cycle
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h0) begin n_bad++; $display("FAIL rstmid_val got=%h exp=0", bus.rs1_val); end
    n_cmp++; if (bus.rs2_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.rs2_busy); end
    n_cmp++; if (bus.rs2_tag !== 4'd0) begin n_bad++; $display("FAIL rstmid_tag got=%h exp=0", bus.rs2_tag); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    #1;
    n_cmp++; if (bus.rs1_val !== 32'h0) begin n_bad++; $display("FAIL rstrel_val got=%h exp=0", bus.rs1_val); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_bad++; $display("FAIL rstrel_busy got=%b exp=0", bus.rs1_busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_issue_commit();
    test_retag();
    test_same_cycle();
    test_clear();
    test_x0();
    test_rdy_hold();
    test_commit_visibility();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with per-register rename status for the out-of-order RISC-V core. Sits between the dispatcher and the reorder buffer: the dispatcher reads source operands and their producer ROB tags here and marks each destination as pending. The ROB retires results into it in program order and flushes all pending marks on a misprediction.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ROB_IDX_W`, 4, ROB tag width (16-entry ROB)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global enable; low = hold all state
- `rs1_addr`, `rs2_addr`  in  5 each  dispatcher source indices
- `rs1_val`, `rs2_val`  out  DATA_W each  committed value
- `rs1_busy`, `rs2_busy`  out  1 each  source awaits an in-flight producer
- `rs1_tag`, `rs2_tag`  out  ROB_IDX_W each  producer ROB id, valid when busy
- `issue_en`  in  1  dispatcher issues an instruction writing `issue_rd`
- `issue_rd`  in  5  destination register
- `issue_rob_id`  in  ROB_IDX_W  ROB slot allocated (ROB `free_rob_id`)
- `commit_en`  in  1  ROB retires head entry
- `commit_rd`  in  5  retired destination
- `commit_val`  in  DATA_W  retired result
- `commit_rob_id`  in  ROB_IDX_W  retired entry's ROB id
- `clear`  in  1  misprediction flush from ROB

## Operation
- State per register i (1..31): `val[i]`, `busy[i]`, `tag[i]`. x0: hardwired val 0, busy 0, tag 0; writes/issues to x0 ignored.
- Reads: combinational from state (plus bypass, see Configuration).
- Commit (`commit_en`, rd≠0): `val[rd] <= commit_val`; `busy[rd] <= 0` only if `tag[rd] == commit_rob_id` and no same-cycle issue to rd.
- Issue (`issue_en`, rd≠0, no `clear`): `busy[rd] <= 1`, `tag[rd] <= issue_rob_id`. Issue overrides commit's busy-clear on same rd; value still written.
- Clear: all `busy <= 0`; same-cycle issue dropped; same-cycle commit still writes `val` (retiring instruction is older than the flush point).
- `rdy` low: no state change; reads still valid.
- Reset values: all `val`, `busy`, `tag` = 0; hence all read outputs 0 while `rst` low.
- No internal FSM beyond per-register busy bit (states FREE ↔ PENDING): FREE→PENDING on issue; PENDING→FREE on tag-matching commit or clear; PENDING→PENDING (retag) on re-issue.

## Timing
- Read latency 0 cycles (combinational).
- Issue/commit/clear take effect at next rising edge with `rdy` high.
- Reset asserts immediately (asynchronous), released synchronously to design via external synchronizer; first update on first edge after `rst` high.
- Tag wrap-around: tags compared for equality only; ROB guarantees ≤16 in flight so no aliasing.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined: if `commit_en` and `commit_rd == rsX_addr ≠ 0` and `commit_rob_id == tag[rsX]`, then `rsX_val = commit_val`, `rsX_busy = 0` same cycle.
- Undefined: reads reflect registered state only; dispatcher sees the commit one cycle later.

## Structure
- Shared package: `rob_id_t` (ROB_IDX_W), `reg_idx_t` (5 b), `word_t` (DATA_W), constant `REG_ZERO = 5'd0`.
- One sub-module: `rf_read_port`, instantiated twice (rs1, rs2); does lookup, x0 masking, optional bypass.

## Test plan
- Reset: drive `rst` low mid-run after writes → all outputs 0 immediately, x5 reads val 0 busy 0 after release.
- Issue x5 tag 3, next cycle read rs1=x5 → busy 1 tag 3; commit rd 5 val 0xDEADBEEF id 3 → next cycle val 0xDEADBEEF busy 0.
- Issue x5 tag 3, then x5 tag 7; commit id 3 val 0x11 → val 0x11, busy 1, tag 7.
- Same-cycle commit x6 id 2 val 0x22 and issue x6 id 9 → val 0x22, busy 1, tag 9.
- Three regs pending, `clear` with issue x8 id 4 → all busy 0, x8 not pending.
- Write/issue x0 val 0x55 → rs1=x0 reads 0, busy 0; with `RF_COMMIT_BYPASS_EN`, commit x5 id 3 val 0x77 while reading x5 → same cycle val 0x77 busy 0.
